// File: rtl/reg_inc_arbiter.sv
// Arbitrates NUM_CORES cores onto one shared register port (increment or load), one op in flight.
// Round-robin by default; define REG_INC_ARB_FIXED_PRIORITY_EN for lowest-index-wins priority.
module reg_inc_arbiter #(
  parameter int NUM_CORES  = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_CORES-1:0]            req,
  input  logic [NUM_CORES-1:0]            op,
  input  logic [NUM_CORES*DATA_WIDTH-1:0] wdata,
  output logic [NUM_CORES-1:0]            ack,
  output logic [$clog2(NUM_CORES)-1:0]    grant_id,
  output logic                            reg_write_en,
  output logic                            reg_inc_en,
  output logic [DATA_WIDTH-1:0]           reg_data_in,
  output logic                            busy
);

  localparam int GW = $clog2(NUM_CORES);

  typedef enum logic [1:0] {IDLE, INC, LOAD, LOAD_WAIT} state_t;

  state_t                  state, state_nx;
  logic [NUM_CORES-1:0]    ack_nx;
  logic [GW-1:0]           grant_nx;
  logic [GW-1:0]           win;
  logic                    we_nx;
  logic                    inc_nx;
  logic                    busy_nx;
  logic [DATA_WIDTH-1:0]   data_nx;

`ifdef REG_INC_ARB_FIXED_PRIORITY_EN
  always_comb begin
    win = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (req[i]) win = i[GW-1:0];
    end
  end
`else
  logic [GW-1:0] last_grant, last_nx;
  logic          found;
  int            idx;

  // Search begins one past the previous winner and wraps.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NUM_CORES; i++) begin
      idx = int'(last_grant) + i;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx[GW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant <= GW'(NUM_CORES - 1);
    else     last_grant <= last_nx;
  end
`endif

  // Outputs are decoded from the next state so they are registered alongside it.
  always_comb begin
    state_nx = state;
    ack_nx   = '0;
    grant_nx = grant_id;
    we_nx    = 1'b0;
    inc_nx   = 1'b0;
    data_nx  = reg_data_in;
`ifndef REG_INC_ARB_FIXED_PRIORITY_EN
    last_nx  = last_grant;
`endif
    case (state)
      IDLE: begin
        if (|req) begin
          grant_nx = win;
`ifndef REG_INC_ARB_FIXED_PRIORITY_EN
          last_nx  = win;
`endif
          if (op[win]) begin
            state_nx = LOAD;
            we_nx    = 1'b1;
            data_nx  = wdata[int'(win)*DATA_WIDTH +: DATA_WIDTH];
          end else begin
            state_nx    = INC;
            inc_nx      = 1'b1;
            ack_nx[win] = 1'b1;
          end
        end
      end
      INC:  state_nx = IDLE;
      LOAD: begin
        // The register applies the write a cycle late; no increment may follow directly.
        state_nx         = LOAD_WAIT;
        ack_nx[grant_id] = 1'b1;
      end
      LOAD_WAIT: state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ack          <= '0;
      grant_id     <= '0;
      reg_write_en <= 1'b0;
      reg_inc_en   <= 1'b0;
      reg_data_in  <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nx;
      ack          <= ack_nx;
      grant_id     <= grant_nx;
      reg_write_en <= we_nx;
      reg_inc_en   <= inc_nx;
      reg_data_in  <= data_nx;
      busy         <= busy_nx;
    end
  end

endmodule

// File: tb/tb_reg_inc_arbiter.sv
// Scoreboard bench for reg_inc_arbiter with a behavioural model of the shared register.
module tb_reg_inc_arbiter;
  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, op;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   ack;
  logic [1:0]     grant_id;
  logic           reg_write_en, reg_inc_en, busy;
  logic [W-1:0]   reg_data_in;

  reg_inc_arbiter #(.NUM_CORES(N), .DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .wdata(wdata),
    .ack(ack), .grant_id(grant_id), .reg_write_en(reg_write_en),
    .reg_inc_en(reg_inc_en), .reg_data_in(reg_data_in), .busy(busy)
  );

  always #5 clk = ~clk;

  // Shared register: writes land one cycle late, an increment in that cycle wins.
  logic [W-1:0] shr = '0;
  logic         wr_dly = 1'b0;
  logic [W-1:0] wr_dat_dly = '0;
  always @(posedge clk) begin
    if (reg_inc_en)  shr <= shr + 16'd1;
    else if (wr_dly) shr <= wr_dat_dly;
    wr_dly     <= reg_write_en;
    wr_dat_dly <= reg_data_in;
  end

  typedef struct {
    int         core;
    logic [W-1:0] val;
    int         cyc;
    logic [W-1:0] wdat;
  } exp_t;

  exp_t         exp_q[$];
  int           n_chk = 0;
  int           n_pass = 0;
  int           cyc = 0;
  int           cnt[N];
  logic [W-1:0] model_val = '0;
  bit           reg_pend = 1'b0;
  logic [W-1:0] reg_exp = '0;
  bit           prev_we = 1'b0;
  int           at;

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic expect_op(int core, bit ld, logic [W-1:0] d, int when);
    exp_t e;
    if (ld) model_val = d;
    else    model_val = model_val + 16'd1;
    e.core = core; e.val = model_val; e.cyc = when; e.wdat = d;
    exp_q.push_back(e);
  endtask

  task automatic issue(int core, bit ld, logic [W-1:0] d, int n);
    cnt[core]            = n;
    op[core]             = ld;
    wdata[core*W +: W]   = d;
    req[core]            = (n > 0);
  endtask

  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    chk("enable_overlap", 32'((reg_inc_en && reg_write_en) || (prev_we && reg_inc_en)), 32'd0);
    chk("ack_onehot", 32'($countones(ack) <= 1), 32'd1);
    prev_we = reg_write_en;
    if (reg_pend) begin
      chk("reg_value", 32'(shr), 32'(reg_exp));
      reg_pend = 1'b0;
    end
    if (reg_write_en) begin
      if (exp_q.size() == 0) chk("write_unexpected", 32'd1, 32'd0);
      else begin
        chk("write_gid", 32'(grant_id), 32'(exp_q[0].core));
        chk("write_data", 32'(reg_data_in), 32'(exp_q[0].wdat));
      end
    end
    if (ack != '0) begin
      if (exp_q.size() == 0) chk("ack_unexpected", 32'(ack), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("ack_core", 32'(ack), 32'd1 << e.core);
        chk("ack_gid", 32'(grant_id), 32'(e.core));
        chk("ack_busy", 32'(busy), 32'd1);
        chk("ack_cycle", cyc, e.cyc);
        reg_pend = 1'b1;
        reg_exp  = e.val;
      end
      for (int i = 0; i < N; i++) if (ack[i] && cnt[i] > 0) cnt[i]--;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) req[i] = (cnt[i] != 0);
  endtask

  task automatic drain(int budget);
    for (int k = 0; k < budget && (exp_q.size() != 0 || reg_pend); k++) step();
    chk("drain_done", 32'(exp_q.size()) + 32'(reg_pend), 32'd0);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_ack"},  32'(ack), 32'd0);
    chk({tag, "_gid"},  32'(grant_id), 32'd0);
    chk({tag, "_we"},   32'(reg_write_en), 32'd0);
    chk({tag, "_inc"},  32'(reg_inc_en), 32'd0);
    chk({tag, "_data"}, 32'(reg_data_in), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b0; req = '0; op = '0; wdata = '0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_init");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Core 2 increments held for four operations: one every second cycle.
    issue(2, 1'b0, '0, 4);
    at = cyc + 1;
    for (int k = 0; k < 4; k++) expect_op(2, 1'b0, '0, at + 1 + 2*k);
    drain(40);

    // Core 1 load: ack lands in the cycle after the write.
    issue(1, 1'b1, 16'h00A5, 1);
    expect_op(1, 1'b1, 16'h00A5, cyc + 3);
    drain(20);

    // Fresh reset, then all four cores increment twice.
    rst = 1'b1; step(); step(); rst = 1'b0;
    for (int c = 0; c < N; c++) issue(c, 1'b0, '0, 2);
    at = cyc + 1;
`ifdef REG_INC_ARB_FIXED_PRIORITY_EN
    for (int c = 0; c < N; c++)
      for (int r = 0; r < 2; r++) expect_op(c, 1'b0, '0, at + 1 + 2*(2*c + r));
`else
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < N; c++) expect_op(c, 1'b0, '0, at + 1 + 2*(4*r + c));
`endif
    drain(60);

    // Load then increment back to back: increment must follow the landed write.
    issue(0, 1'b1, 16'h1234, 1);
    issue(3, 1'b0, '0, 1);
    at = cyc + 1;
    expect_op(0, 1'b1, 16'h1234, at + 2);
    expect_op(3, 1'b0, '0, at + 4);
    drain(20);
    chk("load_then_inc", 32'(shr), 32'h1235);

    // Reset during LOAD_WAIT: outputs clear at once, no ack, write still lands.
    issue(2, 1'b1, 16'h0BEE, 1);
    at = cyc + 1;
    expect_op(2, 1'b1, 16'h0BEE, at + 2);
    step();
    step();
    rst = 1'b1;
    #1 check_reset_outputs("rst_async");
    exp_q.delete();
    cnt[2] = 0; req = '0;
    model_val = 16'h0BEE;
    step(); step();
    rst = 1'b0;
    chk("rst_write_lands", 32'(shr), 32'h0BEE);
    issue(3, 1'b0, '0, 1);
    issue(0, 1'b0, '0, 1);
    at = cyc + 1;
    expect_op(0, 1'b0, '0, at + 1);
    expect_op(3, 1'b0, '0, at + 3);
    drain(20);

    // Cores 1 and 3 compete, core 1 holding for three operations.
    issue(1, 1'b0, '0, 3);
    issue(3, 1'b0, '0, 1);
    at = cyc + 1;
`ifdef REG_INC_ARB_FIXED_PRIORITY_EN
    expect_op(1, 1'b0, '0, at + 1);
    expect_op(1, 1'b0, '0, at + 3);
    expect_op(1, 1'b0, '0, at + 5);
    expect_op(3, 1'b0, '0, at + 7);
`else
    expect_op(1, 1'b0, '0, at + 1);
    expect_op(3, 1'b0, '0, at + 3);
    expect_op(1, 1'b0, '0, at + 5);
    expect_op(1, 1'b0, '0, at + 7);
`endif
    drain(40);
    step();
    chk("idle_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
